// File: rtl/seq_mag_comparator.sv
// Purpose : digit-serial magnitude comparator (A>B / A==B / A<B). It compares DIGIT bits per
//           cycle, starting at the MSB digit, and stops at the first digit that differs.
// Latency : the result appears k cycles after the accepting edge. k is the 1-based position of
//           the first differing digit counted from the MSB, or NDIG when A==B.
// Backpr. : in_ready is high only in IDLE. The result is held in DONE until out_ready.
//           flush aborts the operation from any state.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake; a, b and signed_mode are sampled on acceptance only
//   flush             synchronous abort; it takes priority over both handshakes
//   out_valid/out_ready result handshake; gt/eq/lt are one-hot while out_valid=1
//   ncycles           number of digits examined for the result (1..NDIG), 0 when idle

module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    localparam int NDIG = WIDTH / DIGIT,
    localparam int CNTW = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CNTW-1:0]  ncycles
);

    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              gt_q, gt_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic [CNTW-1:0]   ncycles_q, ncycles_d;

    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [CNTW-1:0]   cnt_inc;

    // The operand registers shift left by one digit after every equal digit. The digit under
    // test (digit idx of the captured value) therefore always sits at the top of the register,
    // so no idx-driven multiplexer is needed.
    assign a_dig   = a_q[WIDTH-1 -: DIGIT];
    assign b_dig   = b_q[WIDTH-1 -: DIGIT];
    assign cnt_inc = cnt_q + CNTW'(1);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        ncycles_d = ncycles_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    a_d = a;
                    b_d = b;
                    // Flipping the sign bit maps two's-complement order onto unsigned order,
                    // so the same digit comparison serves both modes.
                    if (signed_mode) begin
                        a_d[WIDTH-1] = ~a[WIDTH-1];
                        b_d[WIDTH-1] = ~b[WIDTH-1];
                    end
                    idx_d   = IDXW'(NDIG - 1);
                    cnt_d   = '0;
                    state_d = S_CMP;
                end
            end

            S_CMP: begin
                cnt_d = cnt_inc;
                if (a_dig > b_dig) begin
                    gt_d      = 1'b1;
                    ncycles_d = cnt_inc;
                    state_d   = S_DONE;
                end else if (a_dig < b_dig) begin
                    lt_d      = 1'b1;
                    ncycles_d = cnt_inc;
                    state_d   = S_DONE;
                end else if (idx_q == '0) begin
                    eq_d      = 1'b1;
                    ncycles_d = cnt_inc;
                    state_d   = S_DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    gt_d      = 1'b0;
                    eq_d      = 1'b0;
                    lt_d      = 1'b0;
                    ncycles_d = '0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                gt_d      = 1'b0;
                eq_d      = 1'b0;
                lt_d      = 1'b0;
                ncycles_d = '0;
                state_d   = S_IDLE;
            end
        endcase

        // flush wins over every handshake. A result still waiting in DONE is dropped, not delivered.
        if (flush) begin
            gt_d      = 1'b0;
            eq_d      = 1'b0;
            lt_d      = 1'b0;
            ncycles_d = '0;
            state_d   = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            ncycles_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            ncycles_q <= ncycles_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign ncycles   = ncycles_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Purpose : directed and randomised checks of seq_mag_comparator at 16/4, 8/1 and 12/3.
// Latency : results are awaited with a bounded cycle budget per operation.
// Backpr. : out_ready is driven explicitly. A hold phase covers backpressure.

module tb_seq_mag_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        flush;
    logic [2:0]  iv, orr, sm;
    logic [15:0] a0, b0;
    logic [7:0]  a1, b1;
    logic [11:0] a2, b2;
    wire  [2:0]  ir, ov, gtw, eqw, ltw;
    wire  [2:0]  nc0;
    wire  [3:0]  nc1;
    wire  [2:0]  nc2;

    int nerr = 0;
    int nchk = 0;
    int inv_err = 0;
    int xfer0 = 0;

    seq_mag_comparator #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a0), .b(b0),
        .signed_mode(sm[0]), .flush(flush), .out_valid(ov[0]), .out_ready(orr[0]),
        .gt(gtw[0]), .eq(eqw[0]), .lt(ltw[0]), .ncycles(nc0));

    seq_mag_comparator #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a1), .b(b1),
        .signed_mode(sm[1]), .flush(flush), .out_valid(ov[1]), .out_ready(orr[1]),
        .gt(gtw[1]), .eq(eqw[1]), .lt(ltw[1]), .ncycles(nc1));

    seq_mag_comparator #(.WIDTH(12), .DIGIT(3)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a2), .b(b2),
        .signed_mode(sm[2]), .flush(flush), .out_valid(ov[2]), .out_ready(orr[2]),
        .gt(gtw[2]), .eq(eqw[2]), .lt(ltw[2]), .ncycles(nc2));

    // One-hot flags must track out_valid on every instance at all times.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (int'(gtw[i]) + int'(eqw[i]) + int'(ltw[i]) != int'(ov[i]))
                inv_err <= inv_err + 1;
        end
    end

    always @(posedge clk) begin
        if (ov[0] && orr[0])
            xfer0 <= xfer0 + 1;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          mode;
        int          res;   // 4 = gt, 2 = eq, 1 = lt
        int          k;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int get_nc(input int inst);
        case (inst)
            0:       return int'(nc0);
            1:       return int'(nc1);
            default: return int'(nc2);
        endcase
    endfunction

    function automatic int get_res(input int inst);
        return int'({gtw[inst], eqw[inst], ltw[inst]});
    endfunction

    task automatic set_ops(input int inst, input logic [15:0] a, input logic [15:0] b);
        case (inst)
            0: begin a0 = a; b0 = b; end
            1: begin a1 = a[7:0]; b1 = b[7:0]; end
            default: begin a2 = a[11:0]; b2 = b[11:0]; end
        endcase
    endtask

    // Starts at a negedge. Returns at the first negedge with out_valid=1, or when the budget runs out.
    task automatic run_op(input int inst, input logic [15:0] a, input logic [15:0] b, input bit mode,
                          output int lat, output int res, output int nc);
        set_ops(inst, a, b);
        sm[inst] = mode;
        iv[inst] = 1'b1;
        @(posedge clk);
        #1;
        iv[inst] = 1'b0;
        set_ops(inst, 16'($urandom), 16'($urandom));
        sm[inst] = ~mode;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ov[inst] && lat < 40);
        res = get_res(inst);
        nc  = get_nc(inst);
    endtask

    // Called at a negedge while out_valid=1.
    task automatic pop(input int inst, input string nm);
        orr[inst] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        orr[inst] = 1'b0;
        chk({nm, "_ovld_after_pop"}, int'(ov[inst]), 0);
        chk({nm, "_ird_after_pop"}, int'(ir[inst]), 1);
    endtask

    function automatic void model(input int w, input int d, input logic [15:0] a, input logic [15:0] b,
                                  input bit mode, output int res, output int k);
        int mask, av, bv, x, p;
        mask = (1 << w) - 1;
        av = int'(a) & mask;
        bv = int'(b) & mask;
        if (mode) begin
            if (av >= (1 << (w - 1))) av = av - (1 << w);
            if (bv >= (1 << (w - 1))) bv = bv - (1 << w);
        end
        res = (av > bv) ? 4 : ((av < bv) ? 1 : 2);
        x = (av ^ bv) & mask;
        p = -1;
        for (int i = 0; i < w; i++)
            if (x[i]) p = i;
        k = (p >= 0) ? (w / d) - (p / d) : (w / d);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, res, nc, x0, seen, ek, eres, w, d;
        logic [15:0] ra, rb;
        bit rm;

        tbl[0]  = '{16'h1234, 16'h1234, 1'b0, 2, 4};
        tbl[1]  = '{16'h9000, 16'h1FFF, 1'b0, 4, 1};
        tbl[2]  = '{16'h12F0, 16'h1300, 1'b0, 1, 2};
        tbl[3]  = '{16'hFFFF, 16'h0001, 1'b1, 1, 1};
        tbl[4]  = '{16'hFFFF, 16'h0001, 1'b0, 4, 1};
        tbl[5]  = '{16'h8000, 16'h7FFF, 1'b1, 1, 1};
        tbl[6]  = '{16'h0000, 16'h0001, 1'b0, 1, 4};
        tbl[7]  = '{16'h1250, 16'h1240, 1'b0, 4, 3};
        tbl[8]  = '{16'h8000, 16'h8000, 1'b1, 2, 4};
        tbl[9]  = '{16'hFFFE, 16'hFFFF, 1'b1, 1, 4};
        tbl[10] = '{16'h0010, 16'hFFF0, 1'b1, 4, 1};
        tbl[11] = '{16'h7FFF, 16'h8000, 1'b0, 1, 1};
        tbl[12] = '{16'h7FFF, 16'h8000, 1'b1, 4, 1};

        iv = '0; orr = '0; sm = '0; flush = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;

        // Reset state
        #1 rst = 1'b1;
        #10;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_ovld", i), int'(ov[i]), 0);
            chk($sformatf("rst%0d_flags", i), get_res(i), 0);
            chk($sformatf("rst%0d_ncyc", i), get_nc(i), 0);
            chk($sformatf("rst%0d_ird", i), int'(ir[i]), 1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("vec%0d_ird", i), int'(ir[0]), 1);
            run_op(0, tbl[i].a, tbl[i].b, tbl[i].mode, lat, res, nc);
            chk($sformatf("vec%0d_res", i), res, tbl[i].res);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].k);
            chk($sformatf("vec%0d_ncyc", i), nc, tbl[i].k);
            pop(0, $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles while inputs churn
        run_op(0, 16'h0005, 16'h0003, 1'b0, lat, res, nc);
        chk("bp_lat", lat, 4);
        x0 = xfer0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i),
                int'({ov[0], gtw[0], eqw[0], ltw[0], ir[0], nc0}), int'({5'b11000, 3'd4}));
            set_ops(0, 16'($urandom), 16'($urandom));
            iv[0] = (i < 4);
            @(posedge clk);
            @(negedge clk);
        end
        pop(0, "bp");
        chk("bp_one_xfer", xfer0 - x0, 1);
        chk("bp_cleared", get_res(0), 0);

        // Flush in the second CMP cycle, then a fresh compare
        set_ops(0, 16'h1111, 16'h1111);
        iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_cmp_ird", int'(ir[0]), 1);
        chk("flush_cmp_ovld", int'(ov[0]), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov[0]) seen = 1;
        end
        chk("flush_cmp_noresult", seen, 0);
        run_op(0, 16'h0000, 16'h0001, 1'b0, lat, res, nc);
        chk("post_flush_res", res, 1);
        chk("post_flush_lat", lat, 4);
        pop(0, "post_flush");

        // Flush while a result waits in DONE: the result is dropped
        run_op(0, 16'h9000, 16'h1FFF, 1'b0, lat, res, nc);
        x0 = xfer0;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_ovld", int'(ov[0]), 0);
        chk("flush_done_ncyc", get_nc(0), 0);
        chk("flush_done_ird", int'(ir[0]), 1);
        chk("flush_done_noxfer", xfer0 - x0, 0);

        // Flush in IDLE with in_valid: no capture
        set_ops(0, 16'h9000, 16'h0001);
        iv[0] = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        flush = 1'b0;
        chk("flush_idle_ird", int'(ir[0]), 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov[0]) seen = 1;
        end
        chk("flush_idle_noresult", seen, 0);

        // Async reset mid-CMP
        set_ops(0, 16'h1111, 16'h1111);
        iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_cmp_ird", int'(ir[0]), 1);
        chk("arst_cmp_ovld", int'(ov[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov[0]) seen = 1;
        end
        chk("arst_cmp_noresult", seen, 0);

        // Async reset while DONE
        run_op(0, 16'h0005, 16'h0003, 1'b0, lat, res, nc);
        #2 rst = 1'b1;
        #1;
        chk("arst_done_ovld", int'(ov[0]), 0);
        chk("arst_done_flags", get_res(0), 0);
        chk("arst_done_ncyc", get_nc(0), 0);
        chk("arst_done_ird", int'(ir[0]), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random back-to-back compares on the 8/1 and 12/3 instances
        for (int inst = 1; inst < 3; inst++) begin
            w = (inst == 1) ? 8 : 12;
            d = (inst == 1) ? 1 : 3;
            for (int n = 0; n < 40; n++) begin
                ra = 16'($urandom);
                case ($urandom_range(0, 2))
                    0:       rb = ra;
                    1:       rb = ra ^ (16'd1 << $urandom_range(0, w - 1));
                    default: rb = 16'($urandom);
                endcase
                rm = 1'($urandom);
                model(w, d, ra, rb, rm, eres, ek);
                run_op(inst, ra, rb, rm, lat, res, nc);
                chk($sformatf("rnd%0d_%0d_res", inst, n), res, eres);
                chk($sformatf("rnd%0d_%0d_lat", inst, n), lat, ek);
                chk($sformatf("rnd%0d_%0d_ncyc", inst, n), nc, ek);
                pop(inst, $sformatf("rnd%0d_%0d", inst, n));
            end
        end

        @(negedge clk);
        chk("onehot_invariant", inv_err, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
